// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU and the ALU control decoder.
//   - ALUCtrl operation codes (4 bits)
//   - FSM state type for the iterative-multiply sequencer
//   - small helper to recognise the multi-cycle opcode
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_ADDI = 4'b0110;
  localparam logic [3:0] ALU_SRAI = 4'b0111;
  localparam logic [3:0] ALU_LW   = 4'b1000;
  localparam logic [3:0] ALU_SW   = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_OR   = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_mul(input logic [3:0] code);
    return code == ALU_MUL;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier datapath (low XLEN bits of the product).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            load operands, clear accumulator and counter
//   step_i             perform one shift-add iteration
//   clear_i            abort: clear accumulator and counter (highest priority)
//   mcand_i, mplier_i  operands sampled on start_i
//   acc_o              running / final product
//   last_o             the iteration about to be performed is the final one
module mul_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] mcand_i,
  input  logic [XLEN-1:0] mplier_i,
  output logic [XLEN-1:0] acc_o,
  output logic            last_o
);

  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (start_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      // Product bits above XLEN are dropped: the sum wraps modulo 2^XLEN.
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/alu_iter.sv
// EX-stage ALU. Single-cycle ops resolve combinationally; MUL runs on the
// iterative multiplier and holds the pipeline via stall_o.
// Handshake: an instruction retires in the cycle where valid_i=1 and
// stall_o=0; while stall_o=1 the upstream stages hold valid_i/ALUCtrl_i/data
// stable, and the instruction is consumed exactly once.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   valid_i             ID/EX holds a real instruction
//   flush_i             synchronous abort of the EX instruction
//   ALUCtrl_i           operation code
//   data1_i, data2_i    operands
//   data_o, zero_o      result and result==0
//   stall_o             result not ready, hold upstream
//   state_o             sequencer state (debug)
module alu_iter
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [3:0]      ALUCtrl_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic [XLEN-1:0] data_o,
  output logic            zero_o,
  output logic            stall_o,
  output alu_state_e      state_o
);

  alu_state_e      state_q, state_d;
  logic            mul_issue;
  logic            mul_start, mul_step, mul_clear, mul_last;
  logic [XLEN-1:0] mul_acc;
  logic [XLEN-1:0] alu_res;
  logic [4:0]      shamt;

  assign shamt = data2_i[4:0];

  always_comb begin
    alu_res = data1_i & data2_i;
    case (ALUCtrl_i)
      ALU_AND:                   alu_res = data1_i & data2_i;
      ALU_XOR:                   alu_res = data1_i ^ data2_i;
      ALU_SLL:                   alu_res = data1_i << shamt;
      ALU_ADD, ALU_ADDI,
      ALU_LW, ALU_SW:            alu_res = data1_i + data2_i;
      ALU_SUB, ALU_BEQ:          alu_res = data1_i - data2_i;
      ALU_SRAI:                  alu_res = $signed(data1_i) >>> shamt;
      ALU_OR:                    alu_res = data1_i | data2_i;
      default:                   alu_res = data1_i & data2_i;
    endcase
  end

  assign mul_issue = valid_i && is_mul(ALUCtrl_i) && !flush_i;

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    mul_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mul_issue) begin
          mul_start = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mul_step = 1'b1;
        if (mul_last) state_d = ST_DONE;
      end
      // DONE always returns to IDLE, so held MUL inputs cannot retrigger
      // in the retire cycle itself.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d   = ST_IDLE;
      mul_start = 1'b0;
      mul_step  = 1'b0;
      mul_clear = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  mul_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_ni   (rst_i),
    .start_i  (mul_start),
    .step_i   (mul_step),
    .clear_i  (mul_clear),
    .mcand_i  (data1_i),
    .mplier_i (data2_i),
    .acc_o    (mul_acc),
    .last_o   (mul_last)
  );

  // Stall is raised in the issue cycle itself; gating with rst_i makes it
  // drop asynchronously when reset asserts mid-multiply.
  assign stall_o = rst_i && ((state_q == ST_BUSY) ||
                             ((state_q == ST_IDLE) && mul_issue));

  assign data_o  = ((state_q == ST_BUSY) || (state_q == ST_DONE)) ? mul_acc : alu_res;
  assign zero_o  = (data_o == '0);
  assign state_o = state_q;

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;
  import alu_ctrl_pkg::*;

  // clock / reset
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [3:0]  alu_ctrl = ALU_ADD;
  logic [31:0] data1 = 32'd0;
  logic [31:0] data2 = 32'd0;
  logic [31:0] data_o;
  logic        zero_o;
  logic        stall_o;
  alu_state_e  state_o;

  always #5 clk_i = ~clk_i;

  alu_iter #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .flush_i   (flush_i),
    .ALUCtrl_i (alu_ctrl),
    .data1_i   (data1),
    .data2_i   (data2),
    .data_o    (data_o),
    .zero_o    (zero_o),
    .stall_o   (stall_o),
    .state_o   (state_o)
  );

  // scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: a retire is valid_i=1 with stall_o=0
  always @(negedge clk_i) begin
    if (rst_i && valid_i && !stall_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire: got %h expected no result", data_o);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check({mon_name, "_data"}, data_o, mon_exp);
        check({mon_name, "_zero"}, {31'd0, zero_o}, {31'd0, (mon_exp == 32'd0)});
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name, input int exp_stalls);
    int stalls;
    bit done;
    stalls = 0;
    done   = 1'b0;
    @(posedge clk_i); #1;
    alu_ctrl = code; data1 = a; data2 = b; valid_i = 1'b1; flush_i = 1'b0;
    exp_q.push_back(exp);
    name_q.push_back(name);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_i);
      if (stall_o) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got stall after %0d cycles expected release", name, stalls);
    end
    check({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
  endtask

  task automatic idle(input int n);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    repeat (n) @(posedge clk_i);
  endtask

  initial begin
    // reset state: combinational path live, FSM idle, no stall
    alu_ctrl = ALU_ADD; data1 = 32'd1; data2 = 32'd2; valid_i = 1'b0;
    #12;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_state", {30'd0, state_o}, {30'd0, ST_IDLE});
    check("rst_data", data_o, 32'd3);
    @(negedge clk_i); rst_i = 1'b1;

    // single-cycle ops
    issue(ALU_ADD,  32'd5,          32'hFFFF_FFFD, 32'd2,          "add",   0);
    issue(ALU_SUB,  32'd9,          32'd9,         32'd0,          "sub",   0);
    issue(ALU_SRAI, 32'h8000_0000,  32'd4,         32'hF800_0000,  "srai",  0);
    issue(ALU_AND,  32'hF0F0_1234,  32'h0FF0_FF00, 32'h00F0_1200,  "and",   0);
    issue(ALU_XOR,  32'hF0F0_1234,  32'h0FF0_FF00, 32'hFF00_ED34,  "xor",   0);
    issue(ALU_SLL,  32'd1,          32'h0000_003F, 32'h8000_0000,  "sll",   0);
    issue(ALU_OR,   32'h0000_0F00,  32'h0000_00F0, 32'h0000_0FF0,  "or",    0);
    issue(ALU_ADDI, 32'h7FFF_FFFF,  32'd1,         32'h8000_0000,  "addi",  0);
    issue(ALU_LW,   32'd100,        32'hFFFF_FFFC, 32'd96,         "lw",    0);
    issue(ALU_SW,   32'h0000_1000,  32'h0000_0010, 32'h0000_1010,  "sw",    0);
    issue(ALU_BEQ,  32'd5,          32'd7,         32'hFFFF_FFFE,  "beq",   0);
    issue(4'b1100,  32'hF0F0_1234,  32'h0FF0_FF00, 32'h00F0_1200,  "undef", 0);

    // multiplies
    issue(ALU_MUL, 32'd7,          32'd6,         32'd42,         "mul_7x6",  33);
    idle(1);
    check("mul_back_idle", {30'd0, state_o}, {30'd0, ST_IDLE});
    issue(ALU_MUL, 32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFF1,  "mul_neg",  33);
    issue(ALU_MUL, 32'h0001_0000,  32'h0001_0000, 32'd0,          "mul_wrap", 33);

    // back-to-back: second MUL issued in the IDLE cycle after DONE
    issue(ALU_MUL, 32'd2, 32'd3, 32'd6,  "mul_b2b_a", 33);
    issue(ALU_MUL, 32'd4, 32'd5, 32'd20, "mul_b2b_b", 33);
    idle(1);

    // flush in BUSY cycle 5: no retire, next ADD is single-cycle
    @(posedge clk_i); #1;
    alu_ctrl = ALU_MUL; data1 = 32'd7; data2 = 32'd6; valid_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    check("flush_cycle_state", {30'd0, state_o}, {30'd0, ST_BUSY});
    check("flush_cycle_stall", {31'd0, stall_o}, 32'd1);
    issue(ALU_ADD, 32'd10, 32'd20, 32'd30, "add_after_flush", 0);
    check("flush_state", {30'd0, state_o}, {30'd0, ST_IDLE});
    idle(1);

    // async reset in BUSY cycle 10, MUL inputs still held
    @(posedge clk_i); #1;
    alu_ctrl = ALU_MUL; data1 = 32'd7; data2 = 32'd6; valid_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #2;
    check("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    check("async_rst_stall", {31'd0, stall_o}, 32'd0);
    check("async_rst_state", {30'd0, state_o}, {30'd0, ST_IDLE});
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_i   = 1'b1;
    issue(ALU_MUL, 32'd3, 32'd3, 32'd9, "mul_after_rst", 33);
    idle(3);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
